// File: rtl/link_pkg.sv
// Shared definitions for the multi-board match link: FSM state codes and
// the winner code that designates the local board.
package link_pkg;

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_WAIT_CONN = 3'd1,
        S_LINKED    = 3'd2,
        S_PLAY      = 3'd3,
        S_DONE      = 3'd4
    } link_state_t;

    localparam logic [2:0] WINNER_LOCAL = 3'd0;

endpackage : link_pkg

// File: rtl/sync_bus.sv
// Multi-flop synchroniser for a bus of independent asynchronous level signals.
module sync_bus #(
    parameter int WIDTH  = 1,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    logic [STAGES-1:0][WIDTH-1:0] sync_r;

    // shift chain: stage 0 samples the raw pins, last stage is the safe copy
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_r <= '0;
        end else begin
            sync_r <= {sync_r[STAGES-2:0], din};
        end
    end

    assign dout = sync_r[STAGES-1];

endmodule : sync_bus

// File: rtl/match_link_ctrl.sv
// Connect/start/finish handshake controller for a match between the local
// board and NUM_PEERS remote boards, with timeout and link-loss recovery.
module match_link_ctrl
    import link_pkg::*;
#(
    parameter int NUM_PEERS      = 1,
    parameter int SYNC_STAGES    = 2,
    parameter int TIMEOUT_CYCLES = 200000000
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 req_connect,
    input  logic                 req_start,
    input  logic                 req_return,
    input  logic                 local_finish,
    input  logic [NUM_PEERS-1:0] receive_connect,
    input  logic [NUM_PEERS-1:0] receive_start,
    input  logic [NUM_PEERS-1:0] receive_game_finish,
    output logic                 send_connect,
    output logic                 send_start,
    output logic                 send_game_finish,
    output logic [2:0]           state,
    output logic                 game_init,
    output logic                 is_slave,
    output logic [NUM_PEERS-1:0] peer_alive,
    output logic [2:0]           winner,
    output logic                 link_err
);

    localparam int TIMER_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(TIMEOUT_CYCLES - 1);

    logic [NUM_PEERS-1:0] ps_conn_s;
    logic [NUM_PEERS-1:0] ps_start_s;
    logic [NUM_PEERS-1:0] ps_fin_s;

    link_state_t          state_r;
    logic [TIMER_W-1:0]   timer_r;
    logic                 send_connect_r;
    logic                 send_start_r;
    logic                 send_game_finish_r;
    logic                 game_init_r;
    logic                 is_slave_r;
    logic [2:0]           winner_r;
    logic                 link_err_r;

    sync_bus #(.WIDTH(NUM_PEERS), .STAGES(SYNC_STAGES)) u_sync_conn (
        .clk(clk), .rst_n(rst_n), .din(receive_connect), .dout(ps_conn_s)
    );
    sync_bus #(.WIDTH(NUM_PEERS), .STAGES(SYNC_STAGES)) u_sync_start (
        .clk(clk), .rst_n(rst_n), .din(receive_start), .dout(ps_start_s)
    );
    sync_bus #(.WIDTH(NUM_PEERS), .STAGES(SYNC_STAGES)) u_sync_fin (
        .clk(clk), .rst_n(rst_n), .din(receive_game_finish), .dout(ps_fin_s)
    );

    // Peer k reports as winner code k+1; the lowest index wins a tie among peers.
    function automatic logic [2:0] lowest_peer(input logic [NUM_PEERS-1:0] fin);
        logic [2:0] code;
        code = 3'd0;
        for (int i = NUM_PEERS - 1; i >= 0; i--) begin
            if (fin[i]) begin
                code = 3'(i + 1);
            end else begin
                code = code;
            end
        end
        return code;
    endfunction

    // link FSM with all outputs registered; pulses default low every cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r            <= S_IDLE;
            timer_r            <= '0;
            send_connect_r     <= 1'b0;
            send_start_r       <= 1'b0;
            send_game_finish_r <= 1'b0;
            game_init_r        <= 1'b0;
            is_slave_r         <= 1'b0;
            winner_r           <= WINNER_LOCAL;
            link_err_r         <= 1'b0;
        end else begin
            game_init_r <= 1'b0;
            link_err_r  <= 1'b0;
            case (state_r)
                S_IDLE: begin
                    send_connect_r     <= 1'b0;
                    send_start_r       <= 1'b0;
                    send_game_finish_r <= 1'b0;
                    if (req_return) begin
                        state_r <= S_IDLE;
                    end else if (req_connect) begin
                        state_r        <= S_WAIT_CONN;
                        send_connect_r <= 1'b1;
                        // a peer already calling means it clicked first: it leads
                        is_slave_r     <= |ps_conn_s;
                        timer_r        <= '0;
                    end else begin
                        state_r <= S_IDLE;
                    end
                end
                S_WAIT_CONN: begin
                    if (req_return) begin
                        state_r        <= S_IDLE;
                        send_connect_r <= 1'b0;
                        timer_r        <= '0;
                    end else if (&ps_conn_s) begin
                        state_r <= S_LINKED;
                        timer_r <= '0;
                    end else if (timer_r == TIMER_LAST) begin
                        state_r        <= S_IDLE;
                        send_connect_r <= 1'b0;
                        link_err_r     <= 1'b1;
                        timer_r        <= '0;
                    end else if (timer_r != '1) begin
                        timer_r <= timer_r + TIMER_W'(1);
                    end else begin
                        timer_r <= timer_r;
                    end
                end
                S_LINKED, S_PLAY, S_DONE: begin
                    if (req_return) begin
                        state_r            <= S_LINKED;
                        send_start_r       <= 1'b0;
                        send_game_finish_r <= 1'b0;
                    end else if (!(&ps_conn_s)) begin
                        state_r            <= S_IDLE;
                        send_connect_r     <= 1'b0;
                        send_start_r       <= 1'b0;
                        send_game_finish_r <= 1'b0;
                        link_err_r         <= 1'b1;
                    end else if (state_r == S_LINKED) begin
                        if ((!is_slave_r && req_start) || (is_slave_r && (|ps_start_s))) begin
                            state_r      <= S_PLAY;
                            send_start_r <= 1'b1;
                            game_init_r  <= 1'b1;
                            winner_r     <= WINNER_LOCAL;
                        end else begin
                            state_r <= S_LINKED;
                        end
                    end else if (state_r == S_PLAY) begin
                        // simultaneous finish: both sides defer to the master's board
                        if (local_finish && (!is_slave_r || !(|ps_fin_s))) begin
                            state_r            <= S_DONE;
                            winner_r           <= WINNER_LOCAL;
                            send_game_finish_r <= 1'b1;
                        end else if (|ps_fin_s) begin
                            state_r            <= S_DONE;
                            winner_r           <= lowest_peer(ps_fin_s);
                            send_game_finish_r <= 1'b1;
                        end else begin
                            state_r <= S_PLAY;
                        end
                    end else begin
                        state_r <= S_DONE;
                    end
                end
                default: begin
                    state_r            <= S_IDLE;
                    timer_r            <= '0;
                    send_connect_r     <= 1'b0;
                    send_start_r       <= 1'b0;
                    send_game_finish_r <= 1'b0;
                end
            endcase
        end
    end

    assign state            = state_r;
    assign send_connect     = send_connect_r;
    assign send_start       = send_start_r;
    assign send_game_finish = send_game_finish_r;
    assign game_init        = game_init_r;
    assign is_slave         = is_slave_r;
    assign winner           = winner_r;
    assign link_err         = link_err_r;
    assign peer_alive       = ps_conn_s;

endmodule : match_link_ctrl

// File: tb/tb_match_link_ctrl.sv
// Directed bench for match_link_ctrl with three peers and a short connect timeout.
module tb_match_link_ctrl;

    logic       clk;
    logic       rst_n;
    logic       req_connect;
    logic       req_start;
    logic       req_return;
    logic       local_finish;
    logic [2:0] rc;
    logic [2:0] rs;
    logic [2:0] rf;
    logic       send_connect;
    logic       send_start;
    logic       send_game_finish;
    logic [2:0] state;
    logic       game_init;
    logic       is_slave;
    logic [2:0] peer_alive;
    logic [2:0] winner;
    logic       link_err;

    int n_checks;
    int n_fail;

    match_link_ctrl #(
        .NUM_PEERS(3),
        .SYNC_STAGES(2),
        .TIMEOUT_CYCLES(100)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .req_connect(req_connect),
        .req_start(req_start),
        .req_return(req_return),
        .local_finish(local_finish),
        .receive_connect(rc),
        .receive_start(rs),
        .receive_game_finish(rf),
        .send_connect(send_connect),
        .send_start(send_start),
        .send_game_finish(send_game_finish),
        .state(state),
        .game_init(game_init),
        .is_slave(is_slave),
        .peer_alive(peer_alive),
        .winner(winner),
        .link_err(link_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst_n = 1'b0; req_connect = 1'b0; req_start = 1'b0; req_return = 1'b0;
        local_finish = 1'b0; rc = 3'b000; rs = 3'b000; rf = 3'b000;
        tick(2);
        check_val("rst_state", 32'(state), 32'd0);
        check_val("rst_sends", 32'({send_connect, send_start, send_game_finish}), 32'd0);
        check_val("rst_misc", 32'({game_init, is_slave, winner, link_err}), 32'd0);
        rst_n = 1'b1;
        tick(1);

        // req_return beats req_connect in IDLE
        req_return = 1'b1; req_connect = 1'b1;
        tick(1);
        req_return = 1'b0; req_connect = 1'b0;
        check_val("idle_ret_state", 32'(state), 32'd0);
        check_val("idle_ret_conn", 32'(send_connect), 32'd0);

        // timeout: only peers 0,1 answer
        rc = 3'b011;
        tick(3);
        check_val("alive_011", 32'(peer_alive), 32'h3);
        req_connect = 1'b1;
        tick(1);
        req_connect = 1'b0;
        check_val("wait_state", 32'(state), 32'd1);
        check_val("wait_conn", 32'(send_connect), 32'd1);
        check_val("wait_slave", 32'(is_slave), 32'd1);
        tick(99);
        check_val("to_before", 32'(state), 32'd1);
        check_val("to_before_err", 32'(link_err), 32'd0);
        tick(1);
        check_val("to_state", 32'(state), 32'd0);
        check_val("to_err", 32'(link_err), 32'd1);
        check_val("to_conn", 32'(send_connect), 32'd0);
        tick(1);
        check_val("to_err_pulse", 32'(link_err), 32'd0);

        // master connect
        rc = 3'b000;
        tick(3);
        req_connect = 1'b1;
        tick(1);
        req_connect = 1'b0;
        check_val("m_wait", 32'(state), 32'd1);
        check_val("m_master", 32'(is_slave), 32'd0);
        rc = 3'b111;
        tick(2);
        check_val("m_sync_wait", 32'(state), 32'd1);
        tick(1);
        check_val("m_linked", 32'(state), 32'd2);

        req_start = 1'b1;
        tick(1);
        req_start = 1'b0;
        check_val("m_play", 32'(state), 32'd3);
        check_val("m_send_start", 32'(send_start), 32'd1);
        check_val("m_init1", 32'(game_init), 32'd1);
        tick(1);
        check_val("m_init0", 32'(game_init), 32'd0);

        // master tie: local wins
        rf = 3'b110;
        tick(2);
        check_val("m_tie_pre", 32'(state), 32'd3);
        local_finish = 1'b1;
        tick(1);
        local_finish = 1'b0;
        check_val("m_tie_state", 32'(state), 32'd4);
        check_val("m_tie_winner", 32'(winner), 32'd0);
        check_val("m_tie_fin", 32'(send_game_finish), 32'd1);

        rf = 3'b000; req_return = 1'b1;
        tick(1);
        req_return = 1'b0;
        check_val("ret_state", 32'(state), 32'd2);
        check_val("ret_sends", 32'({send_connect, send_start, send_game_finish}), 32'h4);
        tick(2);

        // peer 2 finishes alone
        req_start = 1'b1;
        tick(1);
        req_start = 1'b0;
        rf = 3'b100;
        tick(3);
        check_val("p2_state", 32'(state), 32'd4);
        check_val("p2_winner", 32'(winner), 32'd3);
        rf = 3'b000; req_return = 1'b1;
        tick(1);
        req_return = 1'b0;
        check_val("p2_held", 32'(winner), 32'd3);
        tick(2);

        // link loss in PLAY
        req_start = 1'b1;
        tick(1);
        req_start = 1'b0;
        check_val("ll_play", 32'(state), 32'd3);
        check_val("ll_winner_clr", 32'(winner), 32'd0);
        rc = 3'b110;
        tick(2);
        check_val("ll_pre", 32'(state), 32'd3);
        tick(1);
        check_val("ll_state", 32'(state), 32'd0);
        check_val("ll_err", 32'(link_err), 32'd1);
        check_val("ll_sends", 32'({send_connect, send_start, send_game_finish}), 32'd0);
        tick(1);
        check_val("ll_err_pulse", 32'(link_err), 32'd0);

        // slave connect and start
        rc = 3'b111;
        tick(3);
        req_connect = 1'b1;
        tick(1);
        req_connect = 1'b0;
        check_val("s_slave", 32'(is_slave), 32'd1);
        tick(1);
        check_val("s_linked", 32'(state), 32'd2);
        req_start = 1'b1;
        tick(1);
        req_start = 1'b0;
        check_val("s_ign_start", 32'(state), 32'd2);
        rs = 3'b010;
        tick(2);
        check_val("s_pre_play", 32'(state), 32'd2);
        tick(1);
        check_val("s_play", 32'(state), 32'd3);
        check_val("s_init", 32'(game_init), 32'd1);

        // slave tie: lowest finishing peer wins
        rf = 3'b110;
        tick(2);
        local_finish = 1'b1;
        tick(1);
        local_finish = 1'b0;
        check_val("s_tie_state", 32'(state), 32'd4);
        check_val("s_tie_winner", 32'(winner), 32'd2);

        // back to PLAY, then async reset mid-cycle
        rf = 3'b000; req_return = 1'b1;
        tick(1);
        req_return = 1'b0;
        check_val("s_ret", 32'(state), 32'd2);
        tick(2);
        check_val("s_replay", 32'(state), 32'd3);
        #2;
        rst_n = 1'b0;
        #1;
        check_val("ar_state", 32'(state), 32'd0);
        check_val("ar_sends", 32'({send_connect, send_start, send_game_finish}), 32'd0);
        check_val("ar_misc", 32'({game_init, is_slave, winner, link_err, peer_alive}), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule : tb_match_link_ctrl
